alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester round-robin arbiter in front of one shared, purely
// combinational ALU. Only one operation is in flight at a time.
//   IDLE : pick a winner and accept its operation.
//   EXEC : hold the operands on the ALU for EXEC_CYCLES cycles.
//   RESP : hold the captured result until the consumer takes it.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (N = 0, 1)
//   reqN_op/_a/_b/_cin/_shamt operation presented by requester N
//   alu_opcode/_a/_b/_cin/_shift_amt  registered drive to the shared ALU
//   alu_res/_cout/_zero/_sign/_overflow  combinational ALU results
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   index of the requester that owns the response
//   rsp_res, rsp_flags       captured result and {cout, zero, sign, overflow}
//
// EXEC_CYCLES is legal in the range 1..4.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_cin,
    input  logic [2:0] req0_shamt,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_cin,
    input  logic [2:0] req1_shamt,

    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_shift_amt,

    input  logic [7:0] alu_res,
    input  logic       alu_cout,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       alu_overflow,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_res,
    output logic [3:0] rsp_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter is loaded with EXEC_CYCLES-1 so that the capture happens
    // on the edge where it reads zero, i.e. on the EXEC_CYCLES-th EXEC edge.
    localparam logic [2:0] EXEC_LOAD = 3'(EXEC_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;

    logic [2:0] exec_cnt_reg;
    logic       rr_ptr_reg;          // index of the most recent grant

    logic [3:0] alu_opcode_reg;
    logic [7:0] alu_a_reg;
    logic [7:0] alu_b_reg;
    logic       alu_cin_reg;
    logic [2:0] alu_shift_amt_reg;

    logic       rsp_id_reg;
    logic [7:0] rsp_res_reg;
    logic [3:0] rsp_flags_reg;

    logic [1:0] req_valid;
    logic [1:0] grant_vec;
    logic [1:0] ready_vec;
    logic       win_idx;
    logic       any_valid;
    logic       in_idle;
    logic       accept;
    logic       exec_done;

    assign req_valid = {req1_valid, req0_valid};
    assign any_valid = |req_valid;
    assign exec_done = (exec_cnt_reg == 3'd0);

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the requester that was
    // not granted most recently wins.
    // ------------------------------------------------------------------
    always_comb begin
        win_idx = 1'b0;
        if (req_valid == 2'b11) begin
            win_idx = ~rr_ptr_reg;
        end else if (req_valid[1]) begin
            win_idx = 1'b1;
        end
    end

    // Ready is only offered in IDLE, only to the winner, and never while
    // reset is asserted (the state is IDLE during reset).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_vec[gi] = any_valid && (win_idx == 1'(gi));
            assign ready_vec[gi] = in_idle && !rst && grant_vec[gi];
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_EXEC;
            ST_EXEC: if (exec_done) state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_idle   = (state_reg == ST_IDLE);
        rsp_valid = (state_reg == ST_RESP);
        accept    = |(ready_vec & req_valid);
    end

    // ------------------------------------------------------------------
    // Datapath: ALU drive, EXEC counter, round-robin pointer, response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt_reg      <= 3'd0;
            rr_ptr_reg        <= 1'b1;   // requester 0 wins the first tie
            alu_opcode_reg    <= 4'd0;
            alu_a_reg         <= 8'd0;
            alu_b_reg         <= 8'd0;
            alu_cin_reg       <= 1'b0;
            alu_shift_amt_reg <= 3'd0;
            rsp_id_reg        <= 1'b0;
            rsp_res_reg       <= 8'd0;
            rsp_flags_reg     <= 4'd0;
        end else begin
            if (accept) begin
                alu_opcode_reg    <= win_idx ? req1_op    : req0_op;
                alu_a_reg         <= win_idx ? req1_a     : req0_a;
                alu_b_reg         <= win_idx ? req1_b     : req0_b;
                alu_cin_reg       <= win_idx ? req1_cin   : req0_cin;
                alu_shift_amt_reg <= win_idx ? req1_shamt : req0_shamt;
                rsp_id_reg        <= win_idx;
                rr_ptr_reg        <= win_idx;
                exec_cnt_reg      <= EXEC_LOAD;
            end
            if (state_reg == ST_EXEC) begin
                if (exec_done) begin
                    rsp_res_reg   <= alu_res;
                    rsp_flags_reg <= {alu_cout, alu_zero, alu_sign, alu_overflow};
                end else begin
                    exec_cnt_reg  <= exec_cnt_reg - 3'd1;
                end
            end
        end
    end

    assign alu_opcode    = alu_opcode_reg;
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_cin       = alu_cin_reg;
    assign alu_shift_amt = alu_shift_amt_reg;
    assign rsp_id        = rsp_id_reg;
    assign rsp_res       = rsp_res_reg;
    assign rsp_flags     = rsp_flags_reg;

endmodule
